sm_sdram_responder: RTL

SM_SDRAM_RESPONDER -- requirements
Module: sm_sdram_responder

---
 rtl/sm_sdram_responder_if.sv | 27 ++
 rtl/sm_sdram_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sm_sdram_responder_if.sv
// Command, address and status signals between an SDRAM controller and the responder model.
// The data bus s_dq is a plain inout on the responder, so it is not carried here.
interface sm_sdram_responder_if;
   logic        sd_cke;
   logic        sd_cs;
   logic        sd_ras;
   logic        sd_cas;
   logic        sd_we;
   logic        sd_ldqm;
   logic        sd_udqm;
   logic [1:0]  sd_bs;
   logic [11:0] s_a;
   logic        dq_oe;
   logic [3:0]  bank_open;
   logic        cmd_err;
   logic [1:0]  mode_cl;

   modport master (
      output sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ldqm, sd_udqm, sd_bs, s_a,
      input  dq_oe, bank_open, cmd_err, mode_cl
   );

   modport slave (
      input  sd_cke, sd_cs, sd_ras, sd_cas, sd_we, sd_ldqm, sd_udqm, sd_bs, s_a,
      output dq_oe, bank_open, cmd_err, mode_cl
   );
endinterface

// File: rtl/sm_sdram_responder.sv
// Behavioural SDRAM device: 4 banks, sequential bursts, CAS-latency read pipeline and
// illegal-command reporting.
module sm_sdram_responder #(
   parameter int unsigned ROW_W = 6,
   parameter int unsigned COL_W = 8,
   parameter int unsigned DQ_W  = 16
) (
   input  logic                clkIn,
   input  logic                rst_n,
   sm_sdram_responder_if.slave sd,
   inout  wire  [DQ_W-1:0]     s_dq
);
   localparam int unsigned AW = 2 + ROW_W + COL_W;
   localparam int unsigned HW = DQ_W / 2;

   typedef enum logic [2:0] {CmdNop, CmdAct, CmdRead, CmdWrite, CmdPre, CmdMode} cmd_e;

   cmd_e              cmd;
   logic [1:0]        bs;
   logic              bank_hit;
   logic [AW-1:0]     cmd_addr;
   logic              cl_ok, bl_ok;
   logic              unused_a;

   logic [1:0]        mode_cl_q, mode_cl_d;
   logic [2:0]        bl_q, bl_d;
   logic [3:0]        bank_open_q, bank_open_d;
   logic [ROW_W-1:0]  row_q [4];
   logic [ROW_W-1:0]  row_d [4];
   logic              cmd_err_q, cmd_err_d;
   logic [1:0]        wr_left_q, wr_left_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [1:0]        rd_left_q, rd_left_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [2:0]        pv_q, pv_d;
   logic [AW-1:0]     pa_q [3];
   logic [AW-1:0]     pa_d [3];
   logic              dq_oe_q, dq_oe_d;

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic              iss_vld;
   logic [AW-1:0]     iss_addr;
   logic [AW-1:0]     tap_addr;

   logic [DQ_W-1:0]   mem [2**AW];
   logic [DQ_W-1:0]   dq_q;

   // Next address inside the BL-aligned block (sequential burst wrap).
   function automatic logic [AW-1:0] burst_next(input logic [AW-1:0] a, input logic [2:0] bl);
      logic [COL_W-1:0] m;
      logic [COL_W-1:0] c;
      m = COL_W'(bl - 3'd1);
      c = a[COL_W-1:0];
      return {a[AW-1:COL_W], (c & ~m) | ((c + COL_W'(1)) & m)};
   endfunction

   always_comb begin
      cmd = CmdNop;
      if (!sd.sd_cs) begin
         case ({sd.sd_ras, sd.sd_cas, sd.sd_we})
            3'b011:  cmd = CmdAct;
            3'b101:  cmd = CmdRead;
            3'b100:  cmd = CmdWrite;
            3'b010:  cmd = CmdPre;
            3'b000:  cmd = CmdMode;
            default: cmd = CmdNop;
         endcase
      end
   end

   assign bs       = sd.sd_bs;
   assign bank_hit = bank_open_q[bs];
   assign cmd_addr = {bs, row_q[bs], sd.s_a[COL_W-1:0]};
   assign cl_ok    = (sd.s_a[6:4] == 3'd2) || (sd.s_a[6:4] == 3'd3);
   assign bl_ok    = (sd.s_a[2:0] <= 3'd2);
   assign unused_a = ^sd.s_a;

   always_comb begin
      mode_cl_d   = mode_cl_q;
      bl_d        = bl_q;
      bank_open_d = bank_open_q;
      row_d       = row_q;
      cmd_err_d   = 1'b0;
      wr_left_d   = wr_left_q;
      wr_addr_d   = wr_addr_q;
      rd_left_d   = rd_left_q;
      rd_addr_d   = rd_addr_q;
      wr_en       = 1'b0;
      wr_addr     = wr_addr_q;
      iss_vld     = 1'b0;
      iss_addr    = rd_addr_q;

      case (cmd)
         CmdAct: begin
            cmd_err_d       = bank_hit;
            bank_open_d[bs] = 1'b1;
            row_d[bs]       = sd.s_a[ROW_W-1:0];
         end
         CmdPre: begin
            if (sd.s_a[10]) bank_open_d = '0;
            else            bank_open_d[bs] = 1'b0;
         end
         CmdMode: begin
            if (cl_ok && bl_ok) begin
               mode_cl_d = sd.s_a[5:4];
               bl_d      = 3'd1 << sd.s_a[1:0];
            end else begin
               cmd_err_d = 1'b1;
            end
         end
         CmdRead, CmdWrite: cmd_err_d = !bank_hit;
         default: ;
      endcase

      // Write beats: a new WRITE restarts, a legal READ or any PRECHARGE cancels the rest.
      if (cmd == CmdWrite && bank_hit) begin
         wr_en     = 1'b1;
         wr_addr   = cmd_addr;
         wr_left_d = 2'(bl_q - 3'd1);
         wr_addr_d = burst_next(cmd_addr, bl_q);
      end else if ((cmd == CmdRead && bank_hit) || cmd == CmdPre) begin
         wr_left_d = 2'd0;
      end else if (wr_left_q != 2'd0) begin
         wr_en     = 1'b1;
         wr_left_d = wr_left_q - 2'd1;
         wr_addr_d = burst_next(wr_addr_q, bl_q);
      end

      // Read beats enter the latency pipe one per edge; PRECHARGE does not stop them.
      if (cmd == CmdRead && bank_hit) begin
         iss_vld   = 1'b1;
         iss_addr  = cmd_addr;
         rd_left_d = 2'(bl_q - 3'd1);
         rd_addr_d = burst_next(cmd_addr, bl_q);
      end else if (cmd == CmdWrite && bank_hit) begin
         rd_left_d = 2'd0;
      end else if (rd_left_q != 2'd0) begin
         iss_vld   = 1'b1;
         rd_left_d = rd_left_q - 2'd1;
         rd_addr_d = burst_next(rd_addr_q, bl_q);
      end

      pv_d    = {pv_q[1:0], iss_vld};
      pa_d[0] = iss_addr;
      pa_d[1] = pa_q[0];
      pa_d[2] = pa_q[1];

      dq_oe_d  = (mode_cl_q == 2'd2) ? pv_q[1] : pv_q[2];
      tap_addr = (mode_cl_q == 2'd2) ? pa_q[1] : pa_q[2];
   end

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         mode_cl_q   <= 2'd3;
         bl_q        <= 3'd1;
         bank_open_q <= '0;
         row_q       <= '{default: '0};
         cmd_err_q   <= 1'b0;
         wr_left_q   <= 2'd0;
         wr_addr_q   <= '0;
         rd_left_q   <= 2'd0;
         rd_addr_q   <= '0;
         pv_q        <= '0;
         pa_q        <= '{default: '0};
         dq_oe_q     <= 1'b0;
      end else if (sd.sd_cke) begin
         mode_cl_q   <= mode_cl_d;
         bl_q        <= bl_d;
         bank_open_q <= bank_open_d;
         row_q       <= row_d;
         cmd_err_q   <= cmd_err_d;
         wr_left_q   <= wr_left_d;
         wr_addr_q   <= wr_addr_d;
         rd_left_q   <= rd_left_d;
         rd_addr_q   <= rd_addr_d;
         pv_q        <= pv_d;
         pa_q        <= pa_d;
         dq_oe_q     <= dq_oe_d;
      end
   end

   // Storage is not reset; a read and write to one word on the same edge returns old data.
   always_ff @(posedge clkIn) begin
      if (sd.sd_cke) begin
         if (wr_en && !sd.sd_ldqm) mem[wr_addr][HW-1:0]    <= s_dq[HW-1:0];
         if (wr_en && !sd.sd_udqm) mem[wr_addr][DQ_W-1:HW] <= s_dq[DQ_W-1:HW];
         dq_q <= mem[tap_addr];
      end
   end

   assign s_dq         = dq_oe_q ? dq_q : {DQ_W{1'bz}};
   assign sd.dq_oe     = dq_oe_q;
   assign sd.bank_open = bank_open_q;
   assign sd.cmd_err   = cmd_err_q;
   assign sd.mode_cl   = mode_cl_q;
endmodule
